// File: rtl/ps2_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ps2_frame_rx: PS/2 device-to-host frame receiver with clock glitch filter and frame timeout.
// Optional build macro PS2_PARITY_CHECK_EN drops frames with bad odd parity.
module ps2_frame_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_en,
    input  logic       ps2d,
    input  logic       ps2c,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    logic                  ps2c_meta, ps2c_sync, ps2d_meta, ps2d_sync;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  filt_clk, filt_next, fall_tick;

    logic [1:0]  state, state_next;
    logic [3:0]  n, n_next;
    logic [10:0] frame, frame_next;
    logic [TW-1:0] tcnt, tcnt_next;
    logic        timeout;
    logic        start_ok, stop_ok, accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_meta  <= 1'b1;
            ps2c_sync  <= 1'b1;
            ps2d_meta  <= 1'b1;
            ps2d_sync  <= 1'b1;
            filter_reg <= '1;
            filt_clk   <= 1'b1;
        end else begin
            ps2c_meta  <= ps2c;
            ps2c_sync  <= ps2c_meta;
            ps2d_meta  <= ps2d;
            ps2d_sync  <= ps2d_meta;
            filter_reg <= {ps2c_sync, filter_reg[FILTER_LEN-1:1]};
            filt_clk   <= filt_next;
        end
    end

    // Level changes only after FILTER_LEN identical samples; anything shorter is a glitch.
    always_comb begin
        filt_next = filt_clk;
        if (&filter_reg)
            filt_next = 1'b1;
        else if (~|filter_reg)
            filt_next = 1'b0;
    end

    assign fall_tick = filt_clk & ~filt_next;

    always_comb begin
        state_next = state;
        n_next     = n;
        frame_next = frame;
        tcnt_next  = tcnt;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                tcnt_next = '0;
                if (fall_tick && rx_en) begin
                    frame_next = {ps2d_sync, frame[10:1]};
                    n_next     = 4'd9;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    frame_next = {ps2d_sync, frame[10:1]};
                    tcnt_next  = '0;
                    if (n == 4'd0)
                        state_next = CHECK;
                    else
                        n_next = n - 4'd1;
                end else if (tcnt == TIMEOUT_LAST) begin
                    timeout    = 1'b1;
                    tcnt_next  = '0;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            CHECK: begin
                tcnt_next  = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            n     <= 4'd0;
            frame <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_next;
            n     <= n_next;
            frame <= frame_next;
            tcnt  <= tcnt_next;
        end
    end

    // frame[0]=start, frame[8:1]=data, frame[9]=parity, frame[10]=stop
    assign start_ok = ~frame[0];
    assign stop_ok  = frame[10];

`ifdef PS2_PARITY_CHECK_EN
    logic par_ok;
    assign par_ok = ^frame[9:1];
    assign accept = start_ok & stop_ok & par_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            parity_err <= 1'b0;
        else
            parity_err <= (state == CHECK) && start_ok && stop_ok && !par_ok;
    end
`else
    assign accept     = start_ok & stop_ok;
    assign parity_err = 1'b0;
`endif

    // Pulses are registered so dout and rx_done_tick change in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            dout         <= 8'h00;
        end else begin
            rx_done_tick <= (state == CHECK) && accept;
            frame_err    <= ((state == CHECK) && !(start_ok && stop_ok)) || timeout;
            if ((state == CHECK) && accept)
                dout <= frame[8:1];
        end
    end

endmodule
`default_nettype wire

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive identical ps2c samples required to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles without a filtered falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_en  input  1  receive enable; a new frame may start only while high.
REQ-006 ps2d  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 ps2c  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-008 rx_done_tick  output  1  one-cycle pulse: dout holds a newly accepted byte.
REQ-009 dout  output  8  last accepted data byte, LSB first on the wire.
REQ-010 parity_err  output  1  one-cycle pulse: frame rejected for bad parity.
REQ-011 frame_err  output  1  one-cycle pulse: frame rejected for bad start/stop bit or timeout.

Function
REQ-012 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 Glitch filter: a FILTER_LEN-bit sample shift register on the synchronized ps2c; filtered clock goes 1 when all bits are 1, goes 0 when all bits are 0, and otherwise holds.
REQ-014 fall_tick SHALL be a one-cycle internal pulse on each 1->0 transition of the filtered clock.
REQ-015 Frame format SHALL be 11 bits: start(0), d0..d7, odd parity, stop(1); each bit is sampled from synchronized ps2d in the fall_tick cycle.
REQ-016 FSM states SHALL be IDLE, SHIFT and CHECK.
REQ-017 IDLE: on fall_tick with rx_en=1, shift in the sampled bit, load bit counter n=9, go to SHIFT; fall_tick with rx_en=0 is ignored.
REQ-018 SHIFT: on each fall_tick, right-shift the sample into an 11-bit frame register; if n==0 go to CHECK, else decrement n.
REQ-019 CHECK SHALL last exactly one cycle and then go to IDLE.
REQ-020 CHECK with start=0, stop=1 and odd parity over d0..d7+parity SHALL load dout and pulse rx_done_tick in that cycle.
REQ-021 CHECK with a bad start or stop bit SHALL pulse frame_err; dout is unchanged; no rx_done_tick.
REQ-022 CHECK with good start and stop bits but bad parity SHALL pulse parity_err only (subject to REQ-029/030).
REQ-023 Timeout counter: cleared on every fall_tick and in IDLE; counts in SHIFT; on reaching TIMEOUT_CYC-1 it SHALL pulse frame_err and force IDLE, discarding the partial frame.
REQ-024 Deassertion of rx_en mid-frame SHALL NOT abort the frame in progress.
REQ-025 rx_done_tick, parity_err and frame_err SHALL be mutually exclusive in every cycle.
REQ-026 dout SHALL hold its value between accepted frames.

Reset
REQ-027 On reset: state IDLE; dout=8'h00; rx_done_tick, parity_err and frame_err =0; filter register all ones; filtered clock =1; synchronizers =1; n=0; timeout counter=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no pulse on any output.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN defined: REQ-022 applies as written; a bad-parity frame is dropped.
REQ-030 Macro PS2_PARITY_CHECK_EN undefined: parity is ignored; a frame with good start and stop bits is accepted per REQ-020; parity_err is tied to 0.

Verification
REQ-031 Clean frame 8'hF0 (parity 1) at 10 kHz ps2c, clk 100 MHz -> exactly one rx_done_tick, dout=8'hF0.
REQ-032 Back-to-back frames 8'h1C then 8'hF0 -> two rx_done_ticks, in order, with dout 8'h1C then 8'hF0.
REQ-033 Frame 8'h1C with parity 1 (wrong) -> with macro: parity_err pulse, dout unchanged; without macro: rx_done_tick, dout=8'h1C.
REQ-034 3-cycle ps2c low glitches inserted mid-bit with FILTER_LEN=8 -> no extra bits shifted; 8'h5A received correctly.
REQ-035 ps2c stopped after 5 bits -> frame_err pulse TIMEOUT_CYC cycles after the last edge; next frame 8'h29 received correctly.
REQ-036 reset pulsed after 6 bits, then full frame 8'h33 -> no pulse during reset; dout=8'h33 with a single rx_done_tick.
